cordic_vectoring_iter: RTL and testbench

Iterative circular-vectoring CORDIC engine. It converts a Cartesian pair (X, Y) into a magnitude and an angle, and is the inverse of the rotation-mode slices, which generate sin/cos from an angle. One shared datapath is reused for ITERATIONS clock cycles per operation, under a valid/ready input handshake and a one-cycle result strobe. It sits between the function generator's measurement/feedback path and the phase/amplitude control logic.

---
 rtl/cordic_vectoring_iter_if.sv | 27 ++
 rtl/cordic_vectoring_iter.sv | 150 +++++++++++++++
 tb/tb_cordic_vectoring_iter.sv | 203 ++++++++++++++++++++
 3 files changed

// File: rtl/cordic_vectoring_iter_if.sv
`default_nettype none
// ---------------------------------------------------------------------------
// cordic_vectoring_iter_if : operand handshake and result bus of the CORDIC engine
// Revision: 1.0
// ---------------------------------------------------------------------------
interface cordic_vectoring_iter_if #(
    parameter int BITWIDTH = 8
);
    logic                       valid_i;
    logic                       ready_o;
    logic signed [BITWIDTH-1:0] X_i;
    logic signed [BITWIDTH-1:0] Y_i;
    logic                       valid_o;
    logic signed [BITWIDTH-1:0] mag_o;
    logic signed [BITWIDTH-1:0] angle_o;

    modport master (
        output valid_i, X_i, Y_i,
        input  ready_o, valid_o, mag_o, angle_o
    );

    modport slave (
        input  valid_i, X_i, Y_i,
        output ready_o, valid_o, mag_o, angle_o
    );
endinterface
`default_nettype wire

// File: rtl/cordic_vectoring_iter.sv
`default_nettype none
// ---------------------------------------------------------------------------
// cordic_vectoring_iter : iterative circular-vectoring CORDIC, (X,Y) -> (K*|v|, atan2/pi)
// Revision: 1.0
// ---------------------------------------------------------------------------
module cordic_vectoring_iter #(
    parameter int N_INT          = 0,
    parameter int N_FRAC         = -7,
    parameter int ITERATIONS     = 7,
    parameter int SHIFT_BITWIDTH = 4
) (
    input  wire logic               clk_i,
    input  wire logic               rst_i,
    cordic_vectoring_iter_if.slave  bus
);
    localparam int BW = N_INT - N_FRAC + 1;

    localparam logic signed [BW-1:0] c_MAX   = {1'b0, {(BW-1){1'b1}}};
    localparam logic signed [BW-1:0] c_MIN   = {1'b1, {(BW-1){1'b0}}};
    localparam logic signed [BW-1:0] c_HALF  = {2'b01, {(BW-2){1'b0}}};
    localparam logic signed [BW-1:0] c_NHALF = {2'b11, {(BW-2){1'b0}}};
    localparam logic [SHIFT_BITWIDTH-1:0] c_LAST = SHIFT_BITWIDTH'(ITERATIONS - 1);

    localparam logic [0:0] c_IDLE = 1'b0;
    localparam logic [0:0] c_ITER = 1'b1;

    // Clamp a one-bit-wider sum back into range instead of wrapping.
    function automatic logic signed [BW-1:0] sat(input logic signed [BW:0] v);
        if (v[BW] != v[BW-1])
            return v[BW] ? c_MIN : c_MAX;
        return v[BW-1:0];
    endfunction

    function automatic logic signed [BW-1:0] neg_sat(input logic signed [BW-1:0] a);
        logic signed [BW:0] e;
        e = {a[BW-1], a};
        return sat(-e);
    endfunction

    function automatic logic signed [BW-1:0] atan_lut(input logic [SHIFT_BITWIDTH-1:0] i);
        logic [15:0] t;
        case (int'(i))
            0:       t = 16'd8192;
            1:       t = 16'd4836;
            2:       t = 16'd2555;
            3:       t = 16'd1297;
            4:       t = 16'd651;
            5:       t = 16'd326;
            6:       t = 16'd163;
            7:       t = 16'd81;
            8:       t = 16'd41;
            9:       t = 16'd20;
            10:      t = 16'd10;
            11:      t = 16'd5;
            12:      t = 16'd3;
            13:      t = 16'd1;
            14:      t = 16'd1;
            default: t = 16'd0;
        endcase
        return BW'(t >> (16 - BW));
    endfunction

    logic [0:0]                r_state;
    logic [SHIFT_BITWIDTH-1:0] r_cnt;
    logic signed [BW-1:0]      r_x;
    logic signed [BW-1:0]      r_y;
    logic signed [BW-1:0]      r_z;
    logic signed [BW-1:0]      r_mag;
    logic signed [BW-1:0]      r_angle;
    logic                      r_valid;

    logic signed [BW-1:0] w_px, w_py, w_pz;
    logic signed [BW-1:0] w_xs, w_ys, w_atan;
    logic signed [BW-1:0] w_x_next, w_y_next, w_z_next;
    logic                 w_dir_up;

    // Fold left-half-plane operands into the right half plane by +-90 degrees.
    always_comb begin
        w_px = bus.X_i;
        w_py = bus.Y_i;
        w_pz = '0;
        if (bus.X_i[BW-1]) begin
            if (!bus.Y_i[BW-1]) begin
                w_px = bus.Y_i;
                w_py = neg_sat(bus.X_i);
                w_pz = c_HALF;
            end else begin
                w_px = neg_sat(bus.Y_i);
                w_py = bus.X_i;
                w_pz = c_NHALF;
            end
        end
    end

    assign w_dir_up = r_y[BW-1];
    assign w_xs     = r_x >>> r_cnt;
    assign w_ys     = r_y >>> r_cnt;
    assign w_atan   = atan_lut(r_cnt);

    assign w_x_next = sat(w_dir_up ? ({r_x[BW-1], r_x} - {w_ys[BW-1], w_ys})
                                   : ({r_x[BW-1], r_x} + {w_ys[BW-1], w_ys}));
    assign w_y_next = sat(w_dir_up ? ({r_y[BW-1], r_y} + {w_xs[BW-1], w_xs})
                                   : ({r_y[BW-1], r_y} - {w_xs[BW-1], w_xs}));
    // Angle wraps on purpose: +pi and -pi are the same point.
    assign w_z_next = w_dir_up ? (r_z - w_atan) : (r_z + w_atan);

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_state <= c_IDLE;
            r_cnt   <= '0;
            r_x     <= '0;
            r_y     <= '0;
            r_z     <= '0;
            r_mag   <= '0;
            r_angle <= '0;
            r_valid <= 1'b0;
        end else begin
            r_valid <= 1'b0;
            case (r_state)
                c_IDLE: begin
                    if (bus.valid_i) begin
                        r_x     <= w_px;
                        r_y     <= w_py;
                        r_z     <= w_pz;
                        r_cnt   <= '0;
                        r_state <= c_ITER;
                    end
                end
                default: begin
                    r_x   <= w_x_next;
                    r_y   <= w_y_next;
                    r_z   <= w_z_next;
                    r_cnt <= r_cnt + 1'b1;
                    if (r_cnt == c_LAST) begin
                        r_mag   <= w_x_next;
                        r_angle <= w_z_next;
                        r_valid <= 1'b1;
                        r_state <= c_IDLE;
                    end
                end
            endcase
        end
    end

    assign bus.ready_o = (r_state == c_IDLE);
    assign bus.valid_o = r_valid;
    assign bus.mag_o   = r_mag;
    assign bus.angle_o = r_angle;
endmodule
`default_nettype wire

// File: tb/tb_cordic_vectoring_iter.sv
`default_nettype none
// ---------------------------------------------------------------------------
// tb_cordic_vectoring_iter : directed + random checks against an integer CORDIC model
// Revision: 1.0
// ---------------------------------------------------------------------------
module tb_cordic_vectoring_iter;
    localparam int BW = 8;
    localparam int IT = 7;

    logic clk = 1'b0;
    logic rst;
    int   checks   = 0;
    int   failures = 0;

    always #5 clk = ~clk;

    cordic_vectoring_iter_if #(.BITWIDTH(BW)) bus ();

    cordic_vectoring_iter #(
        .N_INT(0), .N_FRAC(-7), .ITERATIONS(IT), .SHIFT_BITWIDTH(4)
    ) dut (
        .clk_i(clk),
        .rst_i(rst),
        .bus  (bus)
    );

    function automatic int clampv(input int v);
        int lo = -(1 << (BW - 1));
        int hi = (1 << (BW - 1)) - 1;
        return (v > hi) ? hi : ((v < lo) ? lo : v);
    endfunction

    function automatic int wrapv(input int v);
        int r = v & ((1 << BW) - 1);
        return (r >= (1 << (BW - 1))) ? r - (1 << BW) : r;
    endfunction

    task automatic model(input int xi, input int yi, output int m, output int a);
        int tbl [16] = '{8192, 4836, 2555, 1297, 651, 326, 163, 81,
                         41, 20, 10, 5, 3, 1, 1, 0};
        int x, y, z, xn, yn, at;
        bit up;
        if (xi >= 0) begin
            x = xi; y = yi; z = 0;
        end else if (yi >= 0) begin
            x = yi; y = clampv(-xi); z = 1 << (BW - 2);
        end else begin
            x = clampv(-yi); y = xi; z = -(1 << (BW - 2));
        end
        for (int i = 0; i < IT; i++) begin
            up = (y < 0);
            at = tbl[i] >>> (16 - BW);
            xn = up ? clampv(x - (y >>> i)) : clampv(x + (y >>> i));
            yn = up ? clampv(y + (x >>> i)) : clampv(y - (x >>> i));
            z  = wrapv(up ? z - at : z + at);
            x  = xn;
            y  = yn;
        end
        m = x;
        a = z;
    endtask

    task automatic check(input string tag, input int obs, input int exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic check_tol(input string tag, input int obs, input int exp,
                             input int tol, input bit circular);
        int d = obs - exp;
        if (circular) d = wrapv(d);
        checks++;
        assert (d <= tol && d >= -tol) else begin
            failures++;
            $error("FAIL %s: observed %0d expected %0d +-%0d", tag, obs, exp, tol);
        end
    endtask

    // Present one operand, wait for the strobe, compare with the model.
    task automatic run_op(input int xi, input int yi, input string tag,
                          output int m_obs, output int a_obs);
        int m_exp, a_exp, cnt;
        model(xi, yi, m_exp, a_exp);
        bus.X_i     = BW'(xi);
        bus.Y_i     = BW'(yi);
        bus.valid_i = 1'b1;
        check({tag, "_ready_idle"}, int'(bus.ready_o), 1);
        @(posedge clk); #1;
        bus.valid_i = 1'b0;
        cnt = 0;
        while (bus.valid_o !== 1'b1 && cnt < 20) begin
            check({tag, "_ready_busy"}, int'(bus.ready_o), 0);
            @(posedge clk); #1;
            cnt++;
        end
        check({tag, "_latency"}, cnt, IT);
        m_obs = int'(bus.mag_o);
        a_obs = int'(bus.angle_o);
        check({tag, "_mag"}, m_obs, m_exp);
        check({tag, "_angle"}, a_obs, a_exp);
        @(posedge clk); #1;
        check({tag, "_strobe_one_cycle"}, int'(bus.valid_o), 0);
    endtask

    initial begin
        int m, a, xi, yi, m_exp, a_exp;
        int ex [4][2] = '{'{-128, 0}, '{-128, -128}, '{0, -128}, '{127, -128}};

        rst         = 1'b1;
        bus.valid_i = 1'b0;
        bus.X_i     = '0;
        bus.Y_i     = '0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_ready", int'(bus.ready_o), 1);
        check("rst_valid", int'(bus.valid_o), 0);
        check("rst_mag", int'(bus.mag_o), 0);
        check("rst_angle", int'(bus.angle_o), 0);
        rst = 1'b0;
        @(posedge clk); #1;

        run_op(32, 0, "tp_x32", m, a);
        check_tol("tp_x32_mag_ideal", m, 53, 2, 1'b0);
        check_tol("tp_x32_ang_ideal", a, 0, 2, 1'b1);
        run_op(32, 32, "tp_diag", m, a);
        check_tol("tp_diag_mag_ideal", m, 75, 2, 1'b0);
        check_tol("tp_diag_ang_ideal", a, 32, 2, 1'b1);
        run_op(-32, 0, "tp_negx", m, a);
        check_tol("tp_negx_mag_ideal", m, 53, 2, 1'b0);
        check_tol("tp_negx_ang_ideal", a, -128, 2, 1'b1);
        run_op(-32, -32, "tp_q3", m, a);
        check_tol("tp_q3_mag_ideal", m, 75, 2, 1'b0);
        check_tol("tp_q3_ang_ideal", a, -96, 2, 1'b1);
        run_op(127, 127, "tp_sat", m, a);
        check("tp_sat_mag_clamped", m, 127);
        check_tol("tp_sat_ang_ideal", a, 32, 3, 1'b1);

        for (int k = 0; k < 4; k++)
            run_op(ex[k][0], ex[k][1], "edge", m, a);

        repeat (25) begin
            xi = int'($urandom_range(0, 255)) - 128;
            yi = int'($urandom_range(0, 255)) - 128;
            run_op(xi, yi, "rand", m, a);
        end

        // valid_i held high: one result every IT+1 cycles, operands changed mid-run are ignored
        bus.X_i     = BW'(int'($urandom_range(0, 255)) - 128);
        bus.Y_i     = BW'(int'($urandom_range(0, 255)) - 128);
        bus.valid_i = 1'b1;
        for (int k = 0; k < 4; k++) begin
            xi = int'(bus.X_i);
            yi = int'(bus.Y_i);
            model(xi, yi, m_exp, a_exp);
            check("b2b_ready_idle", int'(bus.ready_o), 1);
            @(posedge clk); #1;
            bus.X_i = BW'(int'($urandom_range(0, 255)) - 128);
            bus.Y_i = BW'(int'($urandom_range(0, 255)) - 128);
            for (int j = 0; j < IT; j++) begin
                check("b2b_ready_busy", int'(bus.ready_o), 0);
                @(posedge clk); #1;
            end
            check("b2b_valid", int'(bus.valid_o), 1);
            check("b2b_mag", int'(bus.mag_o), m_exp);
            check("b2b_angle", int'(bus.angle_o), a_exp);
        end
        bus.valid_i = 1'b0;
        @(posedge clk); #1;
        check("b2b_valid_drop", int'(bus.valid_o), 0);

        // Reset mid-ITER with a live operand on the bus
        run_op(40, 20, "pre_abort", m, a);
        bus.X_i     = BW'(50);
        bus.Y_i     = BW'(-30);
        bus.valid_i = 1'b1;
        @(posedge clk); #1;
        bus.valid_i = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        bus.valid_i = 1'b1;
        rst         = 1'b1;
        @(posedge clk); #1;
        rst         = 1'b0;
        bus.valid_i = 1'b0;
        check("abort_ready", int'(bus.ready_o), 1);
        check("abort_valid", int'(bus.valid_o), 0);
        check("abort_mag", int'(bus.mag_o), 0);
        check("abort_angle", int'(bus.angle_o), 0);
        for (int j = 0; j < 12; j++) begin
            @(posedge clk); #1;
            check("abort_no_stray", int'(bus.valid_o), 0);
        end

        run_op(-100, 60, "post_abort", m, a);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
`default_nettype wire
